// File: rtl/flow_ctrl.sv
// rtl/flow_ctrl.sv - control-flow sequencer: run/halt FSM, skip/jump decode, label LUT, loop counter
// Optional call/return link register enabled by defining FLOW_LINK_EN.
module flow_ctrl #(
    parameter int D = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [8:0]   instr,
    input  logic [D-1:0] prog_ctr,
    input  logic         alu_zero,
    input  logic         alu_neg,
    input  logic         lut_we,
    input  logic [4:0]   lut_addr,
    input  logic [7:0]   lut_wdata,
    output logic         pc_rst,
    output logic         branch_en,
    output logic         jump_en,
    output logic [7:0]   target,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_LDC   = 4'b1000;
    localparam logic [3:0] OP_LOOP  = 4'b1001;
    localparam logic [3:0] OP_SETF  = 4'b1010;
    localparam logic [3:0] OP_SKIPF = 4'b1011;
    localparam logic [3:0] OP_JMPF  = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;
    localparam logic [3:0] OP_CALL  = 4'b1110;
    localparam logic [3:0] OP_SYS   = 4'b1111;

    state_t     state;
    logic       flag;
    logic [4:0] loop_cnt;
    logic [7:0] lut [32];

    logic [3:0] op;
    logic [4:0] idx;
    logic       run_ctl;

    assign op      = instr[8:5];
    assign idx     = instr[4:0];
    assign run_ctl = (state == S_RUN) && instr[8];

`ifdef FLOW_LINK_EN
    logic [D-1:0] link;

    always_ff @(posedge clk) begin
        if (reset) begin
            link <= '0;
        end else if (run_ctl && op == OP_CALL) begin
            link <= prog_ctr + 1'b1;
        end
    end
`else
    logic unused_pc_hi;
    assign unused_pc_hi = ^prog_ctr[D-1:8];
`endif

    // Outputs are combinational so the PC acts on the same edge that ends decode.
    always_comb begin
        pc_rst    = (state == S_IDLE);
        branch_en = 1'b0;
        jump_en   = 1'b0;
        target    = 8'h00;
        done      = 1'b0;
        case (state)
            S_DONE: begin
                jump_en = 1'b1;
                target  = prog_ctr[7:0];
                done    = 1'b1;
            end
            S_RUN: begin
                if (instr[8]) begin
                    case (op)
                        OP_LOOP: begin
                            if (loop_cnt != 5'd0) begin
                                jump_en = 1'b1;
                                target  = lut[idx];
                            end
                        end
                        OP_SKIPF: branch_en = flag;
                        OP_JMPF: begin
                            if (flag) begin
                                jump_en = 1'b1;
                                target  = lut[idx];
                            end
                        end
                        OP_JMP: begin
                            jump_en = 1'b1;
                            target  = lut[idx];
                        end
`ifdef FLOW_LINK_EN
                        OP_CALL: begin
                            jump_en = 1'b1;
                            target  = lut[idx];
                        end
`endif
                        OP_SYS: begin
                            if (instr[0]) begin
                                jump_en = 1'b1;
                                target  = prog_ctr[7:0];
                            end else begin
`ifdef FLOW_LINK_EN
                                jump_en = 1'b1;
                                target  = link[7:0];
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            flag     <= 1'b0;
            loop_cnt <= 5'd0;
            for (int i = 0; i < 32; i++) begin
                lut[i] <= 8'h00;
            end
        end else begin
            if (lut_we) begin
                lut[lut_addr] <= lut_wdata;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (run_ctl) begin
                        case (op)
                            OP_LDC:  loop_cnt <= idx;
                            OP_LOOP: begin
                                if (loop_cnt != 5'd0) begin
                                    loop_cnt <= loop_cnt - 5'd1;
                                end
                            end
                            OP_SETF: begin
                                case (instr[1:0])
                                    2'b00:   flag <= alu_zero;
                                    2'b01:   flag <= alu_neg;
                                    2'b10:   flag <= ~alu_zero;
                                    default: flag <= 1'b1;
                                endcase
                            end
                            OP_SYS: begin
                                if (instr[0]) begin
                                    state <= S_DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flow_ctrl.sv
// tb/tb_flow_ctrl.sv - self-checking bench for flow_ctrl with a PC, program memory and reference model
module tb_flow_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  instr = 9'h000;
    logic [11:0] prog_ctr = 12'h000;
    logic        alu_zero = 1'b0;
    logic        alu_neg = 1'b0;
    logic        lut_we = 1'b0;
    logic [4:0]  lut_addr = 5'd0;
    logic [7:0]  lut_wdata = 8'h00;
    logic        pc_rst;
    logic        branch_en;
    logic        jump_en;
    logic [7:0]  target;
    logic        done;

    int errors = 0;
    int checks = 0;
    bit rand_mode = 1'b0;

    logic [11:0] pc = 12'h000;
    logic [8:0]  mem [0:4095];

    flow_ctrl #(.D(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .instr     (instr),
        .prog_ctr  (prog_ctr),
        .alu_zero  (alu_zero),
        .alu_neg   (alu_neg),
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_wdata (lut_wdata),
        .pc_rst    (pc_rst),
        .branch_en (branch_en),
        .jump_en   (jump_en),
        .target    (target),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Program counter as the surrounding datapath implements it.
    always @(posedge clk) begin
        if (pc_rst)         pc <= 12'h000;
        else if (jump_en)   pc <= {pc[11:8], target};
        else if (branch_en) pc <= pc + 12'd2;
        else                pc <= pc + 12'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start  = 1'b0;
        reset  = 1'b0;
        lut_we = 1'b0;
        if (!rand_mode) begin
            instr    = mem[pc];
            prog_ctr = pc;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 9'h000;
    endtask

    task automatic do_reset();
        tick(); reset = 1'b1;
        tick(); reset = 1'b1;
        tick();
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [7:0] d);
        tick();
        lut_we = 1'b1; lut_addr = a; lut_wdata = d;
    endtask

    task automatic launch();
        tick(); start = 1'b1;
        tick();
    endtask

    task automatic run_to(input logic [11:0] addr, input int budget);
        int n = 0;
        while (pc !== addr && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (pc !== addr) begin
            errors++;
            $display("FAIL run_to: pc=%h, wanted %h within %0d cycles", pc, addr, budget);
        end
    endtask

    task automatic test_reset();
        tick(); reset = 1'b1;
        tick(); reset = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (pc_rst !== 1'b1) begin errors++; $display("FAIL reset_pc_rst got=%b exp=1", pc_rst); end
        checks++; if ({branch_en, jump_en, target, done} !== 11'd0) begin
            errors++; $display("FAIL reset_outs got=%h exp=0", {branch_en, jump_en, target, done}); end
        start = 1'b1;
        #1;
        checks++; if (pc_rst !== 1'b1) begin errors++; $display("FAIL start_cycle_pc_rst got=%b exp=1", pc_rst); end
        tick();
        @(negedge clk);
        checks++; if (pc_rst !== 1'b0 || pc !== 12'h000) begin
            errors++; $display("FAIL run_begin got pc_rst=%b pc=%h exp 0/000", pc_rst, pc); end
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h001) begin errors++; $display("FAIL run_advance got=%h exp=001", pc); end
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (pc_rst !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL midrun_reset got pc_rst=%b done=%b exp 1/0", pc_rst, done); end
        start = 1'b1;
        tick();
        tick(); reset = 1'b1; start = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (pc_rst !== 1'b1) begin errors++; $display("FAIL reset_beats_start got=%b exp=1", pc_rst); end
    endtask

    task automatic test_jmp();
        clear_mem();
        mem[12'h005] = {4'b1101, 5'd3};
        mem[12'h040] = {4'b1101, 5'd3};
        mem[12'h060] = 9'h1E1;
        do_reset();
        lut_write(5'd3, 8'h40);
        launch();
        run_to(12'h005, 20);
        @(negedge clk);
        checks++; if ({branch_en, jump_en, target} !== {1'b0, 1'b1, 8'h40}) begin
            errors++; $display("FAIL jmp3 got br=%b j=%b t=%h exp 0/1/40", branch_en, jump_en, target); end
        tick();
        lut_we = 1'b1; lut_addr = 5'd3; lut_wdata = 8'h60;
        @(negedge clk);
        checks++; if (pc !== 12'h040 || target !== 8'h40) begin
            errors++; $display("FAIL jmp_same_cycle_write got pc=%h t=%h exp 040/40", pc, target); end
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h040 || target !== 8'h60) begin
            errors++; $display("FAIL jmp_new_lut got pc=%h t=%h exp 040/60", pc, target); end
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h060 || {jump_en, target, done} !== {1'b1, 8'h60, 1'b0}) begin
            errors++; $display("FAIL halt_decode got pc=%h j=%b t=%h d=%b", pc, jump_en, target, done); end
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h060 || done !== 1'b1) begin
            errors++; $display("FAIL halt_done got pc=%h d=%b exp 060/1", pc, done); end
    endtask

    task automatic test_flag();
        clear_mem();
        mem[12'h00F] = {4'b1010, 3'b000, 2'b00};
        mem[12'h010] = {4'b1011, 5'd0};
        mem[12'h011] = 9'h1E1;
        mem[12'h012] = {4'b1010, 3'b000, 2'b10};
        mem[12'h013] = {4'b1011, 5'd0};
        mem[12'h014] = {4'b1100, 5'd1};
        mem[12'h015] = {4'b1010, 3'b000, 2'b11};
        mem[12'h016] = {4'b1100, 5'd1};
        mem[12'h020] = 9'h1E1;
        alu_zero = 1'b1; alu_neg = 1'b0;
        do_reset();
        lut_write(5'd1, 8'h20);
        launch();
        run_to(12'h00F, 40);
        @(negedge clk);
        checks++; if (branch_en !== 1'b0) begin errors++; $display("FAIL setf_no_branch got=%b exp=0", branch_en); end
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h010 || branch_en !== 1'b1 || jump_en !== 1'b0) begin
            errors++; $display("FAIL skipf_taken got pc=%h br=%b j=%b exp 010/1/0", pc, branch_en, jump_en); end
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h012) begin errors++; $display("FAIL skip_dest got=%h exp=012", pc); end
        tick();
        @(negedge clk);
        checks++; if (branch_en !== 1'b0) begin errors++; $display("FAIL skipf_not_taken got=%b exp=0", branch_en); end
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h014 || jump_en !== 1'b0 || target !== 8'h00) begin
            errors++; $display("FAIL jmpf_not_taken got pc=%h j=%b t=%h exp 014/0/00", pc, jump_en, target); end
        tick();
        tick();
        @(negedge clk);
        checks++; if (jump_en !== 1'b1 || target !== 8'h20) begin
            errors++; $display("FAIL jmpf_taken got j=%b t=%h exp 1/20", jump_en, target); end
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h020) begin errors++; $display("FAIL jmpf_dest got=%h exp=020", pc); end
        alu_zero = 1'b0;
    endtask

    task automatic test_loop();
        int body = 0;
        int jumps = 0;
        int n = 0;
        logic j4 = 1'b1;
        clear_mem();
        mem[12'h001] = {4'b1000, 5'd2};
        mem[12'h003] = {4'b1001, 5'd2};
        mem[12'h004] = {4'b1001, 5'd2};
        mem[12'h005] = 9'h1E1;
        do_reset();
        lut_write(5'd2, 8'h02);
        launch();
        while (pc !== 12'h005 && n < 40) begin
            @(negedge clk);
            if (pc === 12'h002) body++;
            if (pc === 12'h003 && jump_en === 1'b1) jumps++;
            if (pc === 12'h004) j4 = jump_en;
            tick();
            n++;
        end
        checks++; if (body != 3) begin errors++; $display("FAIL loop_body got=%0d exp=3", body); end
        checks++; if (jumps != 2) begin errors++; $display("FAIL loop_jumps got=%0d exp=2", jumps); end
        checks++; if (j4 !== 1'b0) begin errors++; $display("FAIL loop_no_wrap got=%b exp=0", j4); end
    endtask

    task automatic test_halt();
        clear_mem();
        mem[12'h000] = {4'b1101, 5'd0};
        mem[12'h020] = 9'h1E1;
        do_reset();
        lut_write(5'd0, 8'h20);
        launch();
        run_to(12'h020, 10);
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            checks++; if (pc !== 12'h020 || done !== 1'b1) begin
                errors++; $display("FAIL halt_hold[%0d] got pc=%h d=%b exp 020/1", i, pc, done); end
        end
        start = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (pc_rst !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL done_to_idle got pc_rst=%b d=%b exp 1/0", pc_rst, done); end
        start = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h000 || pc_rst !== 1'b0) begin
            errors++; $display("FAIL rerun got pc=%h pc_rst=%b exp 000/0", pc, pc_rst); end
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h020) begin errors++; $display("FAIL rerun_jump got=%h exp=020", pc); end
    endtask

    task automatic test_call();
        clear_mem();
        mem[12'h000] = {4'b1101, 5'd5};
        mem[12'h030] = {4'b1110, 5'd4};
        mem[12'h031] = 9'h1E1;
        mem[12'h080] = 9'h1E0;
        do_reset();
        lut_write(5'd5, 8'h30);
        lut_write(5'd4, 8'h80);
        launch();
        run_to(12'h030, 10);
        @(negedge clk);
`ifdef FLOW_LINK_EN
        checks++; if (jump_en !== 1'b1 || target !== 8'h80) begin
            errors++; $display("FAIL call got j=%b t=%h exp 1/80", jump_en, target); end
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h080 || jump_en !== 1'b1 || target !== 8'h31) begin
            errors++; $display("FAIL ret got pc=%h j=%b t=%h exp 080/1/31", pc, jump_en, target); end
`else
        checks++; if (jump_en !== 1'b0 || target !== 8'h00) begin
            errors++; $display("FAIL call_noop got j=%b t=%h exp 0/00", jump_en, target); end
`endif
        tick();
        @(negedge clk);
        checks++; if (pc !== 12'h031) begin errors++; $display("FAIL call_return_pc got=%h exp=031", pc); end
    endtask

    // Reference model: 0 idle, 1 running, 2 halted.
    int         m_state;
    bit         m_flag;
    int         m_cnt;
    logic [11:0] m_link;
    logic [7:0] m_lut [32];
    logic [11:0] e_vec;

    task automatic model_eval();
        logic [7:0] t = 8'h00;
        bit r = 0, b = 0, j = 0, d = 0;
        logic [4:0] ix;
        ix = instr[4:0];
        if (m_state == 0) r = 1;
        else if (m_state == 2) begin j = 1; t = prog_ctr[7:0]; d = 1; end
        else if (instr[8]) begin
            case (instr[7:5])
                3'b001: if (m_cnt != 0) begin j = 1; t = m_lut[ix]; end
                3'b011: b = m_flag;
                3'b100: if (m_flag) begin j = 1; t = m_lut[ix]; end
                3'b101: begin j = 1; t = m_lut[ix]; end
`ifdef FLOW_LINK_EN
                3'b110: begin j = 1; t = m_lut[ix]; end
`endif
                3'b111: begin
                    if (instr[0]) begin j = 1; t = prog_ctr[7:0]; end
`ifdef FLOW_LINK_EN
                    else begin j = 1; t = m_link[7:0]; end
`endif
                end
                default: ;
            endcase
        end
        e_vec = {r, b, j, t, d};
    endtask

    task automatic model_commit();
        if (reset) begin
            m_state = 0; m_flag = 0; m_cnt = 0; m_link = 12'h000;
            for (int i = 0; i < 32; i++) m_lut[i] = 8'h00;
        end else begin
            if (lut_we) m_lut[lut_addr] = lut_wdata;
            if (m_state == 0) begin
                if (start) m_state = 1;
            end else if (m_state == 2) begin
                if (start) m_state = 0;
            end else if (instr[8]) begin
                case (instr[7:5])
                    3'b000: m_cnt = instr[4:0];
                    3'b001: if (m_cnt > 0) m_cnt = m_cnt - 1;
                    3'b010: case (instr[1:0])
                        2'b00: m_flag = alu_zero;
                        2'b01: m_flag = alu_neg;
                        2'b10: m_flag = !alu_zero;
                        default: m_flag = 1;
                    endcase
                    3'b110: m_link = prog_ctr + 12'd1;
                    3'b111: if (instr[0]) m_state = 2;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic test_random();
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset     = (i == 0) || ($urandom_range(0, 63) == 0);
            start     = ($urandom_range(0, 7) == 0);
            instr     = 9'($urandom);
            instr[8]  = ($urandom_range(0, 3) != 0);
            prog_ctr  = 12'($urandom);
            alu_zero  = 1'($urandom);
            alu_neg   = 1'($urandom);
            lut_we    = ($urandom_range(0, 3) == 0);
            lut_addr  = 5'($urandom);
            lut_wdata = 8'($urandom);
            @(negedge clk);
            if (i > 0) begin
                model_eval();
                checks++;
                if ({pc_rst, branch_en, jump_en, target, done} !== e_vec) begin
                    errors++;
                    $display("FAIL random[%0d] instr=%h got=%h exp=%h", i, instr,
                             {pc_rst, branch_en, jump_en, target, done}, e_vec);
                end
            end
            model_commit();
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_jmp();
        test_flag();
        test_loop();
        test_halt();
        test_call();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
